// File: rtl/rm_lane_scheduler_pkg.sv
// Shared types and constants for the runtime-monitor lane scheduler.
package rm_lane_scheduler_pkg;

  typedef enum logic {
    RM_LANE_FREE = 1'b0,
    RM_LANE_BUSY = 1'b1
  } rm_lane_state_e;

  localparam int RM_TIMEOUT_CNT_W = 8;
  localparam int RM_TIMER_W       = 16;

  // Index width that stays legal (>=1) even for a single-entry range.
  function automatic int rm_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rm_free_lane_finder.sv
// Combinational search of the occupancy vector for the two lowest free lanes.
module rm_free_lane_finder
  import rm_lane_scheduler_pkg::*;
#(
  parameter int NUM_LANES = 5,
  localparam int LANE_W = rm_idx_w(NUM_LANES)
) (
  input  logic [NUM_LANES-1:0] busy,
  output logic [LANE_W-1:0]    first_idx,
  output logic                 first_valid,
  output logic [LANE_W-1:0]    second_idx,
  output logic                 second_valid,
  output logic                 two_free
);

  localparam int CNT_W = $clog2(NUM_LANES + 1);

  logic [CNT_W-1:0] free_cnt;

  always_comb begin
    first_idx    = '0;
    first_valid  = 1'b0;
    second_idx   = '0;
    second_valid = 1'b0;
    free_cnt     = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (!busy[i]) begin
        if (!first_valid) begin
          first_idx   = LANE_W'(i);
          first_valid = 1'b1;
        end else if (!second_valid) begin
          second_idx   = LANE_W'(i);
          second_valid = 1'b1;
        end
        free_cnt = free_cnt + CNT_W'(1);
      end
    end
  end

  assign two_free = (free_cnt >= CNT_W'(2));

endmodule

// File: rtl/rm_lane_scheduler.sv
// Runtime-monitor lane scheduler: hands detector lanes to monitored
// instructions and retires them on release, timeout or pipeline flush.
module rm_lane_scheduler
  import rm_lane_scheduler_pkg::*;
#(
  parameter int NUM_LANES         = 5,
  parameter int NUM_MONITORED_INS = 2,
  parameter int IDX_W             = 8,
  parameter int LANE_TIMEOUT      = 255,
  localparam int LANE_W  = rm_idx_w(NUM_LANES),
  localparam int ITYPE_W = rm_idx_w(NUM_MONITORED_INS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        ins_valid_i,
  input  logic [ITYPE_W-1:0]          ins_itype_i,
  input  logic                        ins_two_lane_i,
  output logic                        ins_ready_o,
  input  logic                        flush_i,
  input  logic [NUM_LANES-1:0]        lane_release_i,
  output logic                        monitor_ins_o,
  output logic [LANE_W-1:0]           lane0_o,
  output logic [LANE_W-1:0]           lane1_o,
  output logic                        two_lane_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic [ITYPE_W-1:0]          itype_o,
  output logic [NUM_LANES-1:0]        lane_busy_o,
  output logic                        timeout_o,
  output logic [RM_TIMEOUT_CNT_W-1:0] timeout_cnt_o
);

  localparam logic [RM_TIMER_W-1:0] TIMEOUT_VAL = RM_TIMER_W'(LANE_TIMEOUT);
  localparam logic [RM_TIMER_W-1:0] CNT_MAX     = RM_TIMER_W'((1 << RM_TIMEOUT_CNT_W) - 1);

  rm_lane_state_e              state_q [NUM_LANES];
  rm_lane_state_e              state_d [NUM_LANES];
  logic [RM_TIMER_W-1:0]       timer_q [NUM_LANES];
  logic [RM_TIMER_W-1:0]       timer_d [NUM_LANES];
  logic [NUM_LANES-1:0]        busy;
  logic [NUM_LANES-1:0]        alloc;
  logic [NUM_LANES-1:0]        timed_out;
  logic [LANE_W-1:0]           first_idx;
  logic [LANE_W-1:0]           second_idx;
  logic                        first_valid;
  logic                        second_valid;
  logic                        two_free;
  logic                        accept;
  logic [RM_TIMER_W-1:0]       timeout_sum;
  logic [RM_TIMEOUT_CNT_W-1:0] timeout_cnt_d;

  logic                        monitor_q;
  logic [LANE_W-1:0]           lane0_q;
  logic [LANE_W-1:0]           lane1_q;
  logic                        two_lane_q;
  logic [IDX_W-1:0]            idx_q;
  logic [ITYPE_W-1:0]          itype_q;
  logic                        timeout_q;
  logic [RM_TIMEOUT_CNT_W-1:0] timeout_cnt_q;
  logic [IDX_W-1:0]            idx_cnt_q;

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      busy[i] = (state_q[i] == RM_LANE_BUSY);
    end
  end

  rm_free_lane_finder #(
    .NUM_LANES (NUM_LANES)
  ) u_finder (
    .busy         (busy),
    .first_idx    (first_idx),
    .first_valid  (first_valid),
    .second_idx   (second_idx),
    .second_valid (second_valid),
    .two_free     (two_free)
  );

  // Readiness looks only at registered occupancy, so a lane released this
  // cycle cannot be handed out until the next one.
  assign ins_ready_o = ~flush_i & (ins_two_lane_i ? two_free : first_valid);
  assign accept      = ins_valid_i & ins_ready_o;

  always_comb begin
    alloc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (accept) begin
        if (first_idx == LANE_W'(i)) begin
          alloc[i] = 1'b1;
        end
        if (ins_two_lane_i && second_valid && (second_idx == LANE_W'(i))) begin
          alloc[i] = 1'b1;
        end
      end
    end
  end

  // Flush and release outrank the timer, so a lane freed by either in its
  // timeout cycle is not counted as timed out.
  always_comb begin
    timed_out = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      case (state_q[i])
        RM_LANE_FREE: begin
          if (alloc[i]) begin
            state_d[i] = RM_LANE_BUSY;
            timer_d[i] = '0;
          end
        end
        RM_LANE_BUSY: begin
          if (flush_i || lane_release_i[i]) begin
            state_d[i] = RM_LANE_FREE;
          end else if (timer_q[i] == TIMEOUT_VAL) begin
            state_d[i]   = RM_LANE_FREE;
            timed_out[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + RM_TIMER_W'(1);
          end
        end
        default: begin
          state_d[i] = RM_LANE_FREE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= RM_LANE_FREE;
        timer_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
      end
    end
  end

  always_comb begin
    timeout_sum = RM_TIMER_W'(timeout_cnt_q);
    for (int i = 0; i < NUM_LANES; i++) begin
      timeout_sum = timeout_sum + RM_TIMER_W'(timed_out[i]);
    end
    timeout_cnt_d = (timeout_sum > CNT_MAX) ? '1 : timeout_sum[RM_TIMEOUT_CNT_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      monitor_q     <= 1'b0;
      lane0_q       <= '0;
      lane1_q       <= '0;
      two_lane_q    <= 1'b0;
      idx_q         <= '0;
      itype_q       <= '0;
      timeout_q     <= 1'b0;
      timeout_cnt_q <= '0;
      idx_cnt_q     <= '0;
    end else begin
      monitor_q     <= accept;
      timeout_q     <= |timed_out;
      timeout_cnt_q <= timeout_cnt_d;
      if (accept) begin
        lane0_q    <= first_idx;
        lane1_q    <= ins_two_lane_i ? second_idx : first_idx;
        two_lane_q <= ins_two_lane_i;
        idx_q      <= idx_cnt_q;
        itype_q    <= ins_itype_i;
        idx_cnt_q  <= idx_cnt_q + IDX_W'(1);
      end
    end
  end

  // A pulse registered just before a flush is suppressed so detectors never
  // arm on an instruction the pipeline is discarding.
  assign monitor_ins_o = monitor_q & ~flush_i;
  assign lane0_o       = lane0_q;
  assign lane1_o       = lane1_q;
  assign two_lane_o    = two_lane_q;
  assign idx_o         = idx_q;
  assign itype_o       = itype_q;
  assign lane_busy_o   = busy;
  assign timeout_o     = timeout_q;
  assign timeout_cnt_o = timeout_cnt_q;

endmodule

// File: tb/tb_rm_lane_scheduler.sv
// Scoreboard bench for rm_lane_scheduler: directed corner sequences followed by
// random traffic, checked against a lane-allocation reference model.
module tb_rm_lane_scheduler;

  localparam int NL  = 5;
  localparam int NMI = 2;
  localparam int IW  = 2;
  localparam int LT  = 4;
  localparam int LW  = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ins_valid;
  logic [0:0]    ins_itype;
  logic          ins_two_lane;
  logic          ins_ready;
  logic          flush;
  logic [NL-1:0] lane_release;
  logic          monitor_ins;
  logic [LW-1:0] lane0;
  logic [LW-1:0] lane1;
  logic          two_lane;
  logic [IW-1:0] idx;
  logic [0:0]    itype;
  logic [NL-1:0] lane_busy;
  logic          timeout;
  logic [7:0]    timeout_cnt;

  always #5 clk = ~clk;

  rm_lane_scheduler #(
    .NUM_LANES         (NL),
    .NUM_MONITORED_INS (NMI),
    .IDX_W             (IW),
    .LANE_TIMEOUT      (LT)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .ins_valid_i    (ins_valid),
    .ins_itype_i    (ins_itype),
    .ins_two_lane_i (ins_two_lane),
    .ins_ready_o    (ins_ready),
    .flush_i        (flush),
    .lane_release_i (lane_release),
    .monitor_ins_o  (monitor_ins),
    .lane0_o        (lane0),
    .lane1_o        (lane1),
    .two_lane_o     (two_lane),
    .idx_o          (idx),
    .itype_o        (itype),
    .lane_busy_o    (lane_busy),
    .timeout_o      (timeout),
    .timeout_cnt_o  (timeout_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int l0;
    int l1;
    bit two;
    int idx;
    int it;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: which lanes are held, the cycle each was granted, the
  // next sequence number and the running timeout tally.
  bit m_busy  [NL];
  int m_alloc [NL];
  int m_idx;
  int m_tcnt;
  bit m_to;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NL; i++) begin
      m_busy[i]  = 1'b0;
      m_alloc[i] = 0;
    end
    m_idx  = 0;
    m_tcnt = 0;
    m_to   = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_monitor_ins"}, int'(monitor_ins), 0);
    check({tag, "_lane0"}, int'(lane0), 0);
    check({tag, "_lane1"}, int'(lane1), 0);
    check({tag, "_two_lane"}, int'(two_lane), 0);
    check({tag, "_idx"}, int'(idx), 0);
    check({tag, "_itype"}, int'(itype), 0);
    check({tag, "_lane_busy"}, int'(lane_busy), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
    check({tag, "_timeout_cnt"}, int'(timeout_cnt), 0);
  endtask

  // Monitor: each issued instruction must appear exactly in its due cycle
  // (masked to zero if flush is high then), and nowhere else.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        if (flush) begin
          check("masked_pulse", int'(monitor_ins), 0);
        end else begin
          check("monitor_ins", int'(monitor_ins), 1);
          check("lane0", int'(lane0), e.l0);
          check("lane1", int'(lane1), e.l1);
          check("two_lane", int'(two_lane), int'(e.two));
          check("idx", int'(idx), e.idx);
          check("itype", int'(itype), e.it);
        end
      end else begin
        check("idle_pulse", int'(monitor_ins), 0);
      end
    end
  end

  // One clock cycle of stimulus; entered and left at posedge+1.
  task automatic applyStimulus(input bit v, input bit [0:0] it, input bit two,
                               input bit fl, input bit [NL-1:0] rel, output bit acc);
    int nfree;
    int l0;
    int l1;
    int nto;
    int bv;
    bit exp_ready;
    ins_valid    = v;
    ins_itype    = it;
    ins_two_lane = two;
    flush        = fl;
    lane_release = rel;
    #1;
    nfree = 0;
    for (int i = 0; i < NL; i++) if (!m_busy[i]) nfree++;
    exp_ready = !fl && (two ? (nfree >= 2) : (nfree >= 1));
    check("ins_ready", int'(ins_ready), int'(exp_ready));
    acc = v && exp_ready;
    l0 = -1;
    l1 = -1;
    if (acc) begin
      for (int i = 0; i < NL; i++) begin
        if (!m_busy[i]) begin
          if (l0 < 0) l0 = i;
          else if (l1 < 0) l1 = i;
        end
      end
      if (!two) l1 = l0;
      exp_q.push_back('{cyc + 1, l0, l1, two, m_idx, int'(it)});
      m_idx = (m_idx + 1) % (1 << IW);
    end
    nto = 0;
    for (int i = 0; i < NL; i++) begin
      if (m_busy[i]) begin
        if (fl || rel[i]) begin
          m_busy[i] = 1'b0;
        end else if (cyc - m_alloc[i] == LT + 1) begin
          m_busy[i] = 1'b0;
          nto++;
        end
      end
    end
    if (acc) begin
      m_busy[l0]  = 1'b1;
      m_alloc[l0] = cyc;
      m_busy[l1]  = 1'b1;
      m_alloc[l1] = cyc;
    end
    m_to   = (nto > 0);
    m_tcnt = (m_tcnt + nto > 255) ? 255 : m_tcnt + nto;
    @(posedge clk);
    #1;
    bv = 0;
    for (int i = 0; i < NL; i++) if (m_busy[i]) bv |= (1 << i);
    checkOutput(bv);
  endtask

  task automatic checkOutput(input int bv);
    check("lane_busy", int'(lane_busy), bv);
    check("timeout", int'(timeout), int'(m_to));
    check("timeout_cnt", int'(timeout_cnt), m_tcnt);
  endtask

  task automatic mid_reset();
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset");
    ins_valid    = 1'b0;
    flush        = 1'b0;
    lane_release = '0;
    reset_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    bit acc;
    bit pend;
    bit [0:0] pit;
    bit ptwo;
    bit fl;
    bit [NL-1:0] rel;
    rst_n        = 1'b0;
    ins_valid    = 1'b0;
    ins_itype    = '0;
    ins_two_lane = 1'b0;
    flush        = 1'b0;
    lane_release = '0;
    reset_model();
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fill all five lanes, then a sixth request must stall until a timeout.
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'(k % 2), 1'b0, 1'b0, '0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'b00100, acc);
    for (int k = 0; k < 8; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, acc);

    // Two-lane grants around holes, then a release racing a timeout.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, acc);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, acc);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 5'b00001, acc);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, '0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'b00010, acc);
    for (int k = 0; k < 6; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, acc);

    // Accept three, flush right behind the third, then reissue and release free lanes.
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, '0, acc);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, acc);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 5'b11110, acc);
    for (int k = 0; k < 7; k++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, acc);

    // Random traffic with a held request, sparse releases and flushes.
    pend = 1'b0;
    pit  = '0;
    ptwo = 1'b0;
    for (int n = 0; n < 3300; n++) begin
      if (n == 300) begin
        mid_reset();
        pend = 1'b0;
      end
      if (!pend) begin
        pend = ($urandom_range(0, 3) != 0);
        pit  = 1'($urandom_range(0, 1));
        ptwo = ($urandom_range(0, 2) == 0);
      end
      fl  = ($urandom_range(0, 63) == 0);
      rel = NL'($urandom & $urandom & $urandom & $urandom);
      applyStimulus(pend, pit, ptwo, fl, rel, acc);
      if (acc) pend = 1'b0;
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, acc);
    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rm_lane_scheduler.md
Name: rm_lane_scheduler

Overview:
- Allocates runtime-monitor lanes to monitored instructions and drives the per-instruction monitor control (monitor_ins, lane0, lane1, two_lane, idx, itype) consumed by the rm_event_detector instances.
- Tracks per-lane occupancy and frees lanes on release from the detectors, on per-lane timeout, or on pipeline flush.
- Sits between the issue stage and the event-detector bank.

Parameters:
- NUM_LANES, 5, number of monitor lanes (>=2)
- NUM_MONITORED_INS, 2, number of monitored instruction types
- IDX_W, 8, width of the instruction sequence index
- LANE_TIMEOUT, 255, busy cycles before a lane is force-freed (>=1, fits in 16 bits)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- ins_valid_i  in  1  monitored instruction request
- ins_itype_i  in  $clog2(NUM_MONITORED_INS)  instruction type
- ins_two_lane_i  in  1  request needs two lanes
- ins_ready_o  out  1  request can be accepted this cycle
- flush_i  in  1  pipeline flush
- lane_release_i  in  NUM_LANES  per-lane release (OR of detector reset_lane for that lane)
- monitor_ins_o  out  1  control valid, single-cycle pulse
- lane0_o  out  $clog2(NUM_LANES)  primary lane
- lane1_o  out  $clog2(NUM_LANES)  secondary lane
- two_lane_o  out  1  lane1_o is in use
- idx_o  out  IDX_W  sequence index of issued instruction
- itype_o  out  $clog2(NUM_MONITORED_INS)  type of issued instruction
- lane_busy_o  out  NUM_LANES  occupancy vector
- timeout_o  out  1  pulse: at least one lane timed out this cycle
- timeout_cnt_o  out  8  saturating count of timeout events

Behaviour:
- Reset: all outputs 0, all lanes FREE, idx counter 0, timeout counters 0.
- Per-lane state machine:
  - FREE -> BUSY on allocation.
  - BUSY -> FREE on lane_release_i[i], on timer == LANE_TIMEOUT, or on flush_i.
  - Release of a FREE lane is ignored.
- Per-lane timer:
  - Cleared on allocation; increments each cycle while BUSY.
  - Reaching LANE_TIMEOUT frees the lane next cycle and pulses timeout_o.
  - Release in the same cycle takes priority, so no timeout is counted.
- ins_ready_o is combinational from registered occupancy only (same-cycle releases not counted):
  - 1 if at least one lane is FREE when ins_two_lane_i=0.
  - 1 if at least two lanes are FREE when ins_two_lane_i=1.
  - Forced 0 while flush_i=1.
- Accept occurs when ins_valid_i && ins_ready_o. Allocation policy:
  - lane0 = lowest-index FREE lane.
  - lane1 = next-lowest FREE lane if two-lane, else lane1 = lane0.
- Latency: control outputs registered.
  - monitor_ins_o=1 exactly one cycle after accept, with lane0_o/lane1_o/two_lane_o/itype_o/idx_o valid.
  - monitor_ins_o=0 otherwise; other control outputs hold their last value.
  - lane_busy_o reflects the allocation in that same cycle.
- idx: assigned value is the current counter, which increments by 1 per accept and wraps modulo 2^IDX_W.
- Back-to-back accepts allowed every cycle while lanes remain.
- Requester must hold ins_valid_i and ins_* stable until accepted.
- flush_i:
  - All lanes FREE next cycle and accept is suppressed.
  - monitor_ins_o next cycle is 0, even if an accept was registered the cycle before flush.
  - idx counter and timeout_cnt_o are not reset.
- Simultaneous events:
  - Release and allocation in one cycle act on disjoint lanes; the released lane becomes allocatable the next cycle.
  - Multiple timeouts in one cycle raise one timeout_o pulse and increment timeout_cnt_o by the number of lanes timed out, saturating at 255.
- Asynchronous reset mid-operation drops all in-flight state immediately.

Decomposition:
- runtime_monitor_ctrl and lane_ctrl remain in ariane_pkg.
- Add to ariane_pkg:
  - rm_lane_state_e {RM_LANE_FREE, RM_LANE_BUSY}
  - constant RM_TIMEOUT_CNT_W = 8
- Sub-module rm_free_lane_finder: combinational; inputs the busy vector; outputs first/second free index, a valid bit for each, and the free-lane count (>=2 flag). One instance.

Test Plan:
- Single-lane fill: NUM_LANES=5, five single-lane requests back-to-back -> lanes 0,1,2,3,4 issued with idx 0..4, one cycle after each accept; ins_ready_o=0 after the fifth accept.
- Two-lane: lanes 0,2 busy, two-lane request -> lane0_o=1, lane1_o=3, two_lane_o=1; with only lane 4 free, a two-lane request sees ins_ready_o=0 while a single-lane request is accepted.
- Release/reuse: all lanes busy, lane_release_i=5'b00100 -> ins_ready_o=1 next cycle; the next request gets lane 2. Releasing an already-free lane leaves occupancy unchanged.
- Timeout: LANE_TIMEOUT=4, allocate lane 0, no release -> lane 0 freed after 4 busy cycles, timeout_o pulses once, timeout_cnt_o=1. Release in the timeout cycle -> timeout_cnt_o unchanged.
- Flush: three lanes busy and a request accepted, flush_i next cycle -> monitor_ins_o=0, lane_busy_o=0 afterwards, next accept issues lane 0 with idx=3.
- idx wrap with IDX_W=2: five accepts -> idx_o sequence 0,1,2,3,0. Reset asserted mid-stream -> all outputs 0 asynchronously, then idx restarts at 0.
